// File: rtl/fifo_vc_if.sv
// fifo_vc_if
//   Handshake bundle for one virtual-channel FWFT FIFO.
//   Ports carried:
//     push, data_in, pop         producer/consumer requests into the FIFO
//     data_out                   head word (zero while empty)
//     empty, full                occupancy extremes
//     almost_full, almost_empty  threshold flags (almost_full pauses upstream)
//     error                      sticky overflow/underflow indication
//     count                      occupancy 0..DEPTH
//   The master modport is the side that pushes and pops.
//   The slave modport is the FIFO itself.
interface fifo_vc_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  error;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output push, data_in, pop,
    input  data_out, empty, full, almost_full, almost_empty, error, count
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, empty, full, almost_full, almost_empty, error, count
  );
endinterface

// File: rtl/fifo_vc.sv
// fifo_vc
//   First-word-fall-through FIFO that feeds one virtual-channel input of the
//   transmit-layer arbiter. The same block also serves as the output FIFOs
//   behind the arbiter; in that role almost_full acts as the pause signal.
//   Ports:
//     clk      single clock; all state changes on the rising edge
//     reset_L  asynchronous active-low reset; discards all stored words
//     bus      fifo_vc_if.slave carrying push/data_in/pop in and
//              data_out/empty/full/almost_full/almost_empty/error/count out
//   The head word is always visible on data_out (zero when empty). A pop
//   advances to the next word, which appears right after the popping edge.
module fifo_vc #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 2,
  parameter int ALMOST_FULL  = 3,
  parameter int ALMOST_EMPTY = 1
) (
  input logic      clk,
  input logic      reset_L,
  fifo_vc_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(ALMOST_FULL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  error_q;

  logic is_full;
  logic is_empty;
  logic do_push;
  logic do_pop;
  logic bad_op;

  // Full and empty come from the occupancy counter, not from comparing the
  // pointers: with natural pointer wrap, rd_ptr == wr_ptr in both cases.
  // When the FIFO is full, a push is still accepted if the same cycle pops.
  // The write then lands in the slot that the pop is vacating, so it is safe.
  // bad_op flags a push into a full FIFO with no pop, or a pop from an empty one.
  always_comb begin
    is_full  = (count_q == DEPTH_CNT);
    is_empty = (count_q == '0);
    do_pop   = bus.pop && !is_empty;
    do_push  = bus.push && (!is_full || do_pop);
    bad_op   = (bus.pop && is_empty) || (bus.push && is_full && !bus.pop);
  end

  // The storage array has no reset. Its contents are meaningless until
  // count says a slot holds a valid word.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers and occupancy. Count moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The error flag is sticky. Only reset clears it.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      error_q <= 1'b0;
    end else if (bad_op) begin
      error_q <= 1'b1;
    end
  end

  // Every flag decodes count directly, so it changes in the same cycle as count.
  assign bus.data_out     = is_empty ? '0 : mem[rd_ptr];
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.error        = error_q;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_vc.sv
// tb_fifo_vc
//   Self-checking bench for fifo_vc (DEPTH=4, ALMOST_FULL=3, ALMOST_EMPTY=1).
//   The first part runs a table of fill/drain/boundary vectors with their
//   expected outputs. Hand-written sequences follow for overflow, a full FIFO
//   with push and pop together, streaming across pointer wrap, and a reset
//   applied between clock edges. The last part is randomised traffic checked
//   against a queue-based model of the FIFO rules.
//   Ports: none (top-level bench).
module tb_fifo_vc;

  localparam int DW = 6;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic clk;
  logic reset_L;

  fifo_vc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_vc #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL(3), .ALMOST_EMPTY(1)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the queue holds the stored words in order, plus a sticky error bit.
  logic [DW-1:0] model_q[$];
  bit            model_err;

  typedef struct {
    bit            push;
    bit            pop;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
    int            exp_count;
    bit            exp_empty;
    bit            exp_full;
    bit            exp_af;
    bit            exp_ae;
    bit            exp_err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(bit p, bit o, logic [DW-1:0] d, logic [DW-1:0] q,
                              int c, bit e, bit f, bit af, bit ae, bit er);
    vec_t v;
    v.push = p; v.pop = o; v.din = d; v.exp_dout = q; v.exp_count = c;
    v.exp_empty = e; v.exp_full = f; v.exp_af = af; v.exp_ae = ae; v.exp_err = er;
    return v;
  endfunction

  // Single comparison point: every check in the bench goes through here.
  task automatic check_val(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output(string tag, logic [DW-1:0] dout, int cnt, bit e,
                              bit f, bit af, bit ae, bit er);
    check_val({tag, " data_out"}, int'(bus.data_out), int'(dout));
    check_val({tag, " count"}, int'(bus.count), cnt);
    check_val({tag, " empty"}, int'(bus.empty), int'(e));
    check_val({tag, " full"}, int'(bus.full), int'(f));
    check_val({tag, " almost_full"}, int'(bus.almost_full), int'(af));
    check_val({tag, " almost_empty"}, int'(bus.almost_empty), int'(ae));
    check_val({tag, " error"}, int'(bus.error), int'(er));
  endtask

  // Compare the DUT against what the queue model says the outputs should be.
  task automatic check_model(string tag);
    int n;
    n = model_q.size();
    check_output(tag, (n == 0) ? '0 : model_q[0], n, n == 0, n == DEPTH,
                 n >= 3, n <= 1, model_err);
  endtask

  // Apply one cycle of FIFO rules to the model, exactly as a user sees them.
  task automatic model_step(bit p, bit o, logic [DW-1:0] d);
    int  n;
    bit  pop_ok;
    bit  push_ok;
    n = model_q.size();
    pop_ok  = o && (n > 0);
    push_ok = p && ((n < DEPTH) || pop_ok);
    if (o && n == 0) model_err = 1'b1;
    if (p && n == DEPTH && !o) model_err = 1'b1;
    if (pop_ok) void'(model_q.pop_front());
    if (push_ok) model_q.push_back(d);
  endtask

  // Drive one cycle: set inputs, take the rising edge, then sample 1 unit after it.
  task automatic apply_stimulus(bit p, bit o, logic [DW-1:0] d);
    bus.push    = p;
    bus.pop     = o;
    bus.data_in = d;
    @(posedge clk);
    model_step(p, o, d);
    #1;
  endtask

  task automatic do_reset();
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    reset_L     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset", '0, 0, 1, 0, 0, 1, 0);
    reset_L = 1'b1;
    model_q.delete();
    model_err = 1'b0;
  endtask

  initial begin
    // Fill, drain, underflow, push+pop on empty, refill, overflow, full push+pop.
    vecs[0]  = mk(1, 0, 6'h34, 6'h34, 1, 0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 0, 6'h36, 6'h34, 2, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 6'h25, 6'h34, 3, 0, 0, 1, 0, 0);
    vecs[3]  = mk(1, 0, 6'h2C, 6'h34, 4, 0, 1, 1, 0, 0);
    vecs[4]  = mk(0, 1, 6'h00, 6'h36, 3, 0, 0, 1, 0, 0);
    vecs[5]  = mk(0, 1, 6'h00, 6'h25, 2, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 6'h00, 6'h2C, 1, 0, 0, 0, 1, 0);
    vecs[7]  = mk(0, 1, 6'h00, 6'h00, 0, 1, 0, 0, 1, 0);
    vecs[8]  = mk(0, 1, 6'h00, 6'h00, 0, 1, 0, 0, 1, 1);
    vecs[9]  = mk(1, 1, 6'h11, 6'h11, 1, 0, 0, 0, 1, 1);
    vecs[10] = mk(1, 0, 6'h12, 6'h11, 2, 0, 0, 0, 0, 1);
    vecs[11] = mk(1, 0, 6'h13, 6'h11, 3, 0, 0, 1, 0, 1);
    vecs[12] = mk(1, 0, 6'h14, 6'h11, 4, 0, 1, 1, 0, 1);
    vecs[13] = mk(1, 0, 6'h3F, 6'h11, 4, 0, 1, 1, 0, 1);
    vecs[14] = mk(1, 1, 6'h15, 6'h12, 4, 0, 1, 1, 0, 1);
    vecs[15] = mk(0, 0, 6'h00, 6'h12, 4, 0, 1, 1, 0, 1);

    reset_L     = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    #2;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].push, vecs[i].pop, vecs[i].din);
      check_output($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_count,
                   vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_af,
                   vecs[i].exp_ae, vecs[i].exp_err);
    end

    // Reset must clear the sticky error. After that, overflow from a clean
    // state must drop the word.
    do_reset();
    apply_stimulus(1, 0, 6'h34);
    apply_stimulus(1, 0, 6'h36);
    apply_stimulus(1, 0, 6'h25);
    apply_stimulus(1, 0, 6'h2C);
    check_output("prefill", 6'h34, 4, 0, 1, 1, 0, 0);
    apply_stimulus(1, 1, 6'h01);
    check_output("full_push_pop", 6'h36, 4, 0, 1, 1, 0, 0);
    apply_stimulus(1, 0, 6'h3F);
    check_output("overflow", 6'h36, 4, 0, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 1, '0);
      check_model($sformatf("drain_after_ovf%0d", i));
    end
    check_val("dropped_word_absent", int'(bus.data_out), 0);

    // Stream across pointer wrap: preload one word, then push and pop together every cycle.
    do_reset();
    apply_stimulus(1, 0, 6'h20);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1, 1, 6'(i + 1));
      check_output($sformatf("stream%0d", i), 6'(i + 1), 1, 0, 0, 0, 1, 0);
    end

    // Reset asserted between edges empties the FIFO before the next edge.
    do_reset();
    apply_stimulus(1, 0, 6'h0A);
    apply_stimulus(1, 0, 6'h0B);
    apply_stimulus(1, 0, 6'h0C);
    bus.push = 1'b0;
    #1;
    check_output("pre_mid_reset", 6'h0A, 3, 0, 0, 1, 0, 0);
    reset_L = 1'b0;
    #1;
    check_output("mid_reset", '0, 0, 1, 0, 0, 1, 0);
    reset_L = 1'b1;
    model_q.delete();
    model_err = 1'b0;
    apply_stimulus(0, 0, '0);
    check_model("after_mid_reset");

    // Random traffic, first biased toward filling and then toward draining.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit p;
      bit o;
      if (i < 200) begin
        p = ($urandom_range(0, 99) < 70);
        o = ($urandom_range(0, 99) < 35);
      end else begin
        p = ($urandom_range(0, 99) < 35);
        o = ($urandom_range(0, 99) < 70);
      end
      apply_stimulus(p, o, 6'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
